// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_port_arbiter_if                                             |
// | Purpose  : Bundles the requester and RAM-side signals of the main-RAM      |
// |            port arbiter.                                                   |
// | Modports : master - the arbiter (drives ram_* outputs, done, line, stall)  |
// |            slave  - the environment (requesters and the RAM model)         |
// | Signals  : i_rd_req/i_addr          icache miss request                    |
// |            d_rd_req/d_wr_req/d_addr/d_wdata  data-path request             |
// |            ram_req/ram_we/ram_addr/ram_wdata/ram_ack/ram_rdata  RAM port   |
// |            i_done/d_done/o_line/o_stall  results back to the pipeline      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128,
   parameter int DATA_W = 32
);
   logic              i_rd_req;
   logic [ADDR_W-1:0] i_addr;
   logic              d_rd_req;
   logic              d_wr_req;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              ram_ack;
   logic [LINE_W-1:0] ram_rdata;
   logic              ram_req;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              i_done;
   logic              d_done;
   logic [LINE_W-1:0] o_line;
   logic              o_stall;

   modport master (
      input  i_rd_req, i_addr, d_rd_req, d_wr_req, d_addr, d_wdata,
      input  ram_ack, ram_rdata,
      output ram_req, ram_we, ram_addr, ram_wdata,
      output i_done, d_done, o_line, o_stall
   );

   modport slave (
      output i_rd_req, i_addr, d_rd_req, d_wr_req, d_addr, d_wdata,
      output ram_ack, ram_rdata,
      input  ram_req, ram_we, ram_addr, ram_wdata,
      input  i_done, d_done, o_line, o_stall
   );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                                |
// | Purpose  : Shares the single main-RAM port between the icache miss path    |
// |            and the data path (dcache line fill, write-through store).      |
// |            One requester is granted at a time; the RAM req/ack handshake   |
// |            is driven from captured request values, the line or store       |
// |            completion is returned with a one-cycle done pulse.             |
// | Ports    : clk   - clock, rising edge                                      |
// |            rstn  - asynchronous active-low reset                           |
// |            bus   - mem_port_arbiter_if.master (requests, RAM, results)     |
// | Macro    : ARB_ROUND_ROBIN_EN - round-robin between data and instruction   |
// |            classes; undefined gives fixed priority d_wr > d_rd > i_rd.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128,
   parameter int DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 rstn,
   mem_port_arbiter_if.master   bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] c_LINE_MASK = {{(ADDR_W-4){1'b1}}, 4'b0000};

   state_t            r_state;
   state_t            w_stateNext;

   logic              r_ramReq;
   logic              r_ramWe;
   logic [ADDR_W-1:0] r_ramAddr;
   logic [DATA_W-1:0] r_ramWdata;
   logic              r_iDone;
   logic              r_dDone;
   logic [LINE_W-1:0] r_line;
   logic              r_ownerData;     // 1 = data class owns the current transaction

   logic              w_anyReq;
   logic              w_dataReq;
   logic              w_grantData;
   logic              w_grantWr;
   logic [ADDR_W-1:0] w_grantAddr;
   logic [ADDR_W-1:0] w_reqAddr;
   logic              w_iExcl;
   logic              w_dExcl;

   assign w_dataReq = bus.d_rd_req | bus.d_wr_req;
   assign w_anyReq  = w_dataReq | bus.i_rd_req;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_lastData;                  // 1 = data class was granted last

   // On contention the class that did not win last time is granted.
   assign w_grantData = w_dataReq & (~bus.i_rd_req | ~r_lastData);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_lastData <= 1'b0;
      end else if ((r_state == ST_IDLE) && w_anyReq) begin
         r_lastData <= w_grantData;
      end
   end
`else
   assign w_grantData = w_dataReq;
`endif

   // Within the data class the store always wins over the line fill.
   assign w_grantWr   = w_grantData & bus.d_wr_req;
   assign w_grantAddr = w_grantData ? bus.d_addr : bus.i_addr;
   assign w_reqAddr   = w_grantWr ? w_grantAddr : (w_grantAddr & c_LINE_MASK);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_IDLE: if (w_anyReq)    w_stateNext = ST_BUSY;
         ST_BUSY: if (bus.ram_ack) w_stateNext = ST_RESP;
         ST_RESP:                  w_stateNext = ST_IDLE;
         default:                  w_stateNext = ST_IDLE;
      endcase
   end

   // RAM-side and result registers. Everything the RAM sees is captured at
   // grant time, so requesters may drop or change their lines mid-transaction.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ramReq    <= 1'b0;
         r_ramWe     <= 1'b0;
         r_ramAddr   <= '0;
         r_ramWdata  <= '0;
         r_iDone     <= 1'b0;
         r_dDone     <= 1'b0;
         r_line      <= '0;
         r_ownerData <= 1'b0;
      end else begin
         r_iDone <= 1'b0;
         r_dDone <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_anyReq) begin
                  r_ramReq    <= 1'b1;
                  r_ramWe     <= w_grantWr;
                  r_ramAddr   <= w_reqAddr;
                  r_ramWdata  <= w_grantWr ? bus.d_wdata : '0;
                  r_ownerData <= w_grantData;
               end
            end
            ST_BUSY: begin
               if (bus.ram_ack) begin
                  r_ramReq <= 1'b0;
                  if (!r_ramWe) begin
                     r_line <= bus.ram_rdata;
                  end
                  r_iDone <= ~r_ownerData;
                  r_dDone <= r_ownerData;
               end
            end
            default: ;
         endcase
      end
   end

   // During the done cycle the owner's own request no longer stalls the
   // pipeline: it is being answered this cycle. Only the other class can keep
   // the stall asserted then.
   assign w_iExcl = (r_state == ST_RESP) & ~r_ownerData;
   assign w_dExcl = (r_state == ST_RESP) &  r_ownerData;

   assign bus.o_stall   = (r_state == ST_BUSY)
                        | (bus.i_rd_req & ~w_iExcl)
                        | (w_dataReq    & ~w_dExcl);

   assign bus.ram_req   = r_ramReq;
   assign bus.ram_we    = r_ramWe;
   assign bus.ram_addr  = r_ramAddr;
   assign bus.ram_wdata = r_ramWdata;
   assign bus.i_done    = r_iDone;
   assign bus.d_done    = r_dDone;
   assign bus.o_line    = r_line;

endmodule
`default_nettype wire
